mux_rr_n: RTL and testbench
===========================

Name: mux_rr_n

Overview:
Registered N-channel multiplexer with per-channel valid/ready handshake. It generalises the combinational 4x1 mux to CANAIS channels of BITS bits. It has two selection modes: fixed (external SEL) and automatic round-robin across requesting channels. It sits between several producers (counters, memories, sensor front-ends) and one consumer, such as a display or serial transmitter, that needs a stable registered word and a source tag.

Parameters:
BITS, 4, data width per channel (>=1)
CANAIS, 4, number of input channels (2..16)
SELW, derived as clog2(CANAIS) (localparam, not overridable), width of SEL, CANAL_OUT and internal pointer

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset
D  input  CANAIS*BITS  flattened data; channel i = D[i*BITS +: BITS]
D_VALID  input  CANAIS  channel i presents valid data
D_READY  output  CANAIS  channel i word accepted this cycle (one-hot or zero)
MODO  input  1  0 = fixed select via SEL, 1 = round-robin
SEL  input  SELW  selected channel in fixed mode
MUX_OUT  output  BITS  registered output word
CANAL_OUT  output  SELW  index of channel that produced MUX_OUT
OUT_VALID  output  1  MUX_OUT holds an unconsumed word
OUT_READY  input  1  consumer accepts word when high with OUT_VALID
ERRO  output  1  registered flag: fixed mode with SEL >= CANAIS

Behaviour:
- Single clock domain. Reset synchronous and active-low, sampled on rising clock edge.
- Reset values: MUX_OUT = 0, CANAL_OUT = 0, OUT_VALID = 0, ERRO = 0, round-robin pointer ULT = CANAIS-1 (so the first search starts at channel 0).
- Load condition: carga = (!OUT_VALID || OUT_READY) && (chosen channel exists).
- Chosen channel in fixed mode (MODO=0):
  - Chosen channel is SEL, if SEL < CANAIS and D_VALID[SEL]=1.
  - If SEL >= CANAIS: no channel chosen. ERRO = 1 on the next edge, held while the condition persists.
  - MUX_OUT is never loaded from an out-of-range channel.
- Chosen channel in round-robin mode (MODO=1):
  - Chosen channel is the first i with D_VALID[i]=1, scanning ULT+1, ULT+2, ... with wrap modulo CANAIS.
  - ULT updates to the chosen index on each load.
  - ERRO = 0 in this mode.
- D_READY[i] = carga && (i == chosen). Combinational from D_VALID, SEL, MODO, OUT_VALID, OUT_READY and ULT. No path from D data to D_READY.
- On carga: MUX_OUT <= chosen data, CANAL_OUT <= chosen index, OUT_VALID <= 1.
- Output consumed with no new load (OUT_VALID && OUT_READY && !carga): OUT_VALID <= 0. MUX_OUT and CANAL_OUT hold their last values.
- Latency is 1 cycle from accepted input to OUT_VALID. Throughput is 1 word/cycle while OUT_READY=1.
- Backpressure: while OUT_VALID=1 and OUT_READY=0, all D_READY = 0. MUX_OUT, CANAL_OUT and ULT are stable.
- Mode or SEL change takes effect on the same cycle's choice. ULT is kept across mode changes and is not updated in fixed mode.
- Reset while OUT_VALID=1: the pending word is discarded and all registers take their reset values.
- Registered output only; MUX_OUT does not depend combinationally on D.

Decomposition:
- Verilog header mux_rr_n_defs.vh holds `define MODO_FIXO 1'b0 and `define MODO_RR 1'b1. No other shared typedefs.
- Sub-module arbitro_rr_n (parameter CANAIS): purely combinational round-robin picker.
  - Inputs: request vector, pointer.
  - Outputs: grant index, grant-valid.
  - Implemented with a double-width masked priority scan.
- The top level contains the output register, ULT register, ERRO register and handshake logic.

Test Plan:
1. CANAIS=4, BITS=8, MODO=0, SEL=2, D ch2=8'hA5 valid, OUT_READY=1 -> D_READY=4'b0100 same cycle; next cycle MUX_OUT=A5, CANAL_OUT=2, OUT_VALID=1.
2. MODO=1, all D_VALID=4'b1111, OUT_READY=1 for 6 cycles -> CANAL_OUT sequence 0,1,2,3,0,1; exactly one D_READY bit per cycle.
3. MODO=1, D_VALID=4'b1010, ULT=1 -> grant ch3, then ch1, then ch3 (wrap, idle channels skipped).
4. OUT_VALID=1, OUT_READY=0 for 3 cycles with all D_VALID high -> D_READY=0, MUX_OUT/CANAL_OUT unchanged; OUT_READY=1 -> new word loaded next cycle.
5. CANAIS=3, MODO=0, SEL=3 -> ERRO=1 next cycle, D_READY=0, OUT_VALID falls after consumption; SEL=0 -> ERRO=0 next cycle.
6. reset_n=0 for 1 cycle while OUT_VALID=1 -> next edge: all outputs 0, OUT_VALID=0; first round-robin grant afterwards is ch0.

Source files
------------

// File: rtl/arbitro_rr_n.sv
// Combinational round-robin picker: first requester strictly after ptr,
// found by a priority scan over the request vector doubled and masked.
module arbitro_rr_n #(
    parameter  int CANAIS = 4,
    localparam int SELW   = $clog2(CANAIS)
) (
    input  logic [CANAIS-1:0] req,
    input  logic [SELW-1:0]   ptr,
    output logic [SELW-1:0]   gnt_idx,
    output logic              gnt_valid
);

    logic [2*CANAIS-1:0] req_dbl;
    logic [2*CANAIS-1:0] mask;
    logic [2*CANAIS-1:0] masked;

    assign req_dbl = {req, req};

    // Window ptr+1 .. ptr+CANAIS covers every channel exactly once.
    always_comb begin
        mask = '0;
        for (int k = 0; k < 2*CANAIS; k++) begin
            mask[k] = (k > int'(ptr)) && (k <= int'(ptr) + CANAIS);
        end
    end

    assign masked = req_dbl & mask;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the loop can leave it unassigned and infer a latch.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = 2*CANAIS-1; k >= 0; k--) begin
            if (masked[k]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SELW'(k >= CANAIS ? k - CANAIS : k);
            end
        end
    end

endmodule

// File: rtl/mux_rr_n_defs.vh
// Shared mode encodings for the mux_rr_n selection input MODO.
`ifndef MUX_RR_N_DEFS_VH
`define MUX_RR_N_DEFS_VH

`define MODO_FIXO 1'b0
`define MODO_RR   1'b1

`endif

// File: rtl/mux_rr_n.sv
// Registered N-channel mux with valid/ready handshake on every channel and
// on the output; fixed (SEL) or round-robin channel selection.
`include "mux_rr_n_defs.vh"

module mux_rr_n #(
    parameter  int BITS   = 4,
    parameter  int CANAIS = 4,
    localparam int SELW   = $clog2(CANAIS)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [CANAIS*BITS-1:0] D,
    input  logic [CANAIS-1:0]      D_VALID,
    output logic [CANAIS-1:0]      D_READY,
    input  logic                   MODO,
    input  logic [SELW-1:0]        SEL,
    output logic [BITS-1:0]        MUX_OUT,
    output logic [SELW-1:0]        CANAL_OUT,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic                   ERRO
);

    logic [SELW-1:0] ult;
    logic [SELW-1:0] arb_idx;
    logic            arb_valid;
    logic            sel_ok;
    logic            fix_valid;
    logic [SELW-1:0] chosen_idx;
    logic            chosen_valid;
    logic            carga;
    logic [BITS-1:0] chosen_data;

    arbitro_rr_n #(.CANAIS(CANAIS)) u_arbitro (
        .req       (D_VALID),
        .ptr       (ult),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    assign sel_ok = {1'b0, SEL} < (SELW+1)'(CANAIS);

    // Matching SEL against each real channel keeps an out-of-range SEL from
    // ever indexing past D_VALID.
    always_comb begin
        fix_valid = 1'b0;
        for (int i = 0; i < CANAIS; i++) begin
            if (SEL == SELW'(i) && D_VALID[i]) fix_valid = 1'b1;
        end
    end

    assign chosen_idx   = (MODO == `MODO_RR) ? arb_idx   : SEL;
    assign chosen_valid = (MODO == `MODO_RR) ? arb_valid : fix_valid;
    assign carga        = (!OUT_VALID || OUT_READY) && chosen_valid;

    always_comb begin
        D_READY     = '0;
        chosen_data = '0;
        for (int i = 0; i < CANAIS; i++) begin
            if (chosen_idx == SELW'(i)) begin
                D_READY[i]  = carga;
                chosen_data = D[i*BITS +: BITS];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            MUX_OUT   <= '0;
            CANAL_OUT <= '0;
            OUT_VALID <= 1'b0;
            ERRO      <= 1'b0;
            ult       <= SELW'(CANAIS - 1);
        end else begin
            ERRO <= (MODO == `MODO_FIXO) && !sel_ok;
            if (carga) begin
                MUX_OUT   <= chosen_data;
                CANAL_OUT <= chosen_idx;
                OUT_VALID <= 1'b1;
                if (MODO == `MODO_RR) ult <= chosen_idx;
            end else if (OUT_VALID && OUT_READY) begin
                OUT_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_n.sv
// Self-checking bench for mux_rr_n: a 4-channel instance against a
// behavioural model, plus a 3-channel instance for out-of-range SEL.
module tb_mux_rr_n;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    // 4-channel, 8-bit instance
    logic [31:0] d4;
    logic [3:0]  dv4, dr4;
    logic        modo4, ordy4, ov4, erro4;
    logic [1:0]  sel4, canal4;
    logic [7:0]  mux4;

    // 3-channel, 4-bit instance
    logic [11:0] d3;
    logic [2:0]  dv3, dr3;
    logic        modo3, ordy3, ov3, erro3;
    logic [1:0]  sel3, canal3;
    logic [3:0]  mux3;

    mux_rr_n #(.BITS(8), .CANAIS(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .D(d4), .D_VALID(dv4), .D_READY(dr4),
        .MODO(modo4), .SEL(sel4), .MUX_OUT(mux4), .CANAL_OUT(canal4),
        .OUT_VALID(ov4), .OUT_READY(ordy4), .ERRO(erro4)
    );

    mux_rr_n #(.BITS(4), .CANAIS(3)) dut3 (
        .clock(clock), .reset_n(reset_n), .D(d3), .D_VALID(dv3), .D_READY(dr3),
        .MODO(modo3), .SEL(sel3), .MUX_OUT(mux3), .CANAL_OUT(canal3),
        .OUT_VALID(ov3), .OUT_READY(ordy3), .ERRO(erro3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state for dut4
    logic       m_valid;
    logic [7:0] m_data;
    int         m_chan;
    int         m_ult;

    function automatic void pick(input logic modo, input int sel, input logic [3:0] dv,
                                 input int ult, output logic ok, output int idx);
        ok  = 1'b0;
        idx = 0;
        if (!modo) begin
            if (sel < 4 && dv[sel]) begin
                ok  = 1'b1;
                idx = sel;
            end
        end else begin
            for (int off = 1; off <= 4; off++) begin
                int c;
                c = (ult + off) % 4;
                if (!ok && dv[c]) begin
                    ok  = 1'b1;
                    idx = c;
                end
            end
        end
    endfunction

    // One clock of dut4: compare everything against the model, then advance it.
    task automatic cycle();
        logic       ok, ld;
        int         idx;
        logic [3:0] er;
        #1;
        pick(modo4, int'(sel4), dv4, m_ult, ok, idx);
        ld = (!m_valid || ordy4) && ok;
        er = ld ? 4'(1 << idx) : 4'b0;
        check("d_ready", dr4, er);
        check("mux_out", mux4, m_data);
        check("canal_out", canal4, m_chan);
        check("out_valid", ov4, m_valid);
        check("erro", erro4, 0);
        @(posedge clock);
        if (!reset_n) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_chan  = 0;
            m_ult   = 3;
        end else if (ld) begin
            m_valid = 1'b1;
            m_data  = d4[idx*8 +: 8];
            m_chan  = idx;
            if (modo4) m_ult = idx;
        end else if (m_valid && ordy4) begin
            m_valid = 1'b0;
        end
        @(negedge clock);
    endtask

    task automatic tick3();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        int         rr_seq[6];
        int         wrap_seq[3];
        int         rr3_seq[4];
        logic [7:0] held_mux;
        logic [1:0] held_chan;

        rr_seq   = '{0, 1, 2, 3, 0, 1};
        wrap_seq = '{3, 1, 3};
        rr3_seq  = '{0, 1, 2, 0};

        d4 = '0; dv4 = '0; modo4 = 1'b0; sel4 = '0; ordy4 = 1'b1;
        d3 = '0; dv3 = '0; modo3 = 1'b0; sel3 = '0; ordy3 = 1'b1;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        m_valid = 1'b0; m_data = 8'h00; m_chan = 0; m_ult = 3;

        check("rst_mux_out", mux4, 0);
        check("rst_canal_out", canal4, 0);
        check("rst_out_valid", ov4, 0);
        check("rst_erro", erro4, 0);
        reset_n = 1'b1;

        // Fixed select of channel 2
        modo4 = 1'b0; sel4 = 2'd2; dv4 = 4'b0100; d4 = {8'h33, 8'hA5, 8'h11, 8'h00};
        #1 check("fix_d_ready", dr4, 4'b0100);
        cycle();
        check("fix_mux_out", mux4, 8'hA5);
        check("fix_canal_out", canal4, 2);
        check("fix_out_valid", ov4, 1);

        // Round-robin, all channels requesting
        modo4 = 1'b1; dv4 = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            d4 = $urandom;
            #1 check("rr_one_hot", $countones(dr4), 1);
            cycle();
            check("rr_seq", canal4, rr_seq[i]);
        end

        // Sparse requests skip idle channels and wrap
        dv4 = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            d4 = $urandom;
            cycle();
            check("rr_wrap", canal4, wrap_seq[i]);
        end

        // Backpressure holds everything
        dv4 = 4'b1111; ordy4 = 1'b0;
        held_mux = mux4; held_chan = canal4;
        for (int i = 0; i < 3; i++) begin
            d4 = $urandom;
            #1 check("bp_d_ready", dr4, 0);
            cycle();
            check("bp_mux_hold", mux4, held_mux);
            check("bp_chan_hold", canal4, held_chan);
        end
        ordy4 = 1'b1; d4 = {8'h44, 8'h33, 8'h22, 8'h5A};
        cycle();
        check("bp_release_chan", canal4, 0);
        check("bp_release_data", mux4, 8'h5A);

        // Reset with a pending word, then first round-robin grant is channel 0
        check("pre_rst_valid", ov4, 1);
        reset_n = 1'b0;
        cycle();
        check("mid_rst_valid", ov4, 0);
        check("mid_rst_mux", mux4, 0);
        reset_n = 1'b1; d4 = {8'h44, 8'h33, 8'h22, 8'hC3};
        #1 check("post_rst_ready", dr4, 4'b0001);
        cycle();
        check("post_rst_data", mux4, 8'hC3);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            d4      = $urandom;
            dv4     = 4'($urandom);
            modo4   = 1'($urandom);
            sel4    = 2'($urandom);
            ordy4   = ($urandom_range(0, 9) < 7);
            reset_n = ($urandom_range(0, 49) != 0);
            cycle();
        end
        reset_n = 1'b1; dv4 = '0;

        // 3-channel instance: out-of-range SEL raises ERRO
        modo3 = 1'b0; sel3 = 2'd0; dv3 = 3'b001; d3 = 12'h007; ordy3 = 1'b1;
        #1 check("c3_fix_ready", dr3, 3'b001);
        tick3();
        check("c3_mux_out", mux3, 4'h7);
        check("c3_out_valid", ov3, 1);
        check("c3_erro_low", erro3, 0);
        sel3 = 2'd3; dv3 = 3'b111;
        #1 check("c3_oor_ready", dr3, 0);
        tick3();
        check("c3_erro_set", erro3, 1);
        check("c3_valid_drop", ov3, 0);
        check("c3_mux_hold", mux3, 4'h7);
        tick3();
        check("c3_erro_hold", erro3, 1);
        sel3 = 2'd0; dv3 = 3'b000;
        tick3();
        check("c3_erro_clear", erro3, 0);

        // 3-channel round-robin wraps at 3
        modo3 = 1'b1; dv3 = 3'b111;
        for (int i = 0; i < 4; i++) begin
            tick3();
            check("c3_rr_seq", canal3, rr3_seq[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
